// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the SDRAM channel arbiter.
//   arb_state_t : arbiter FSM state encoding
//   DEF_*       : default CPU burst bound and busy-rise timeout
//   idx_width() : requester index width ($clog2 of the requester count, min 1)
package sdram_arb_pkg;

   localparam int unsigned DEF_NREQ      = 3;
   localparam int unsigned DEF_CPU_BURST = 2;
   localparam int unsigned DEF_BUSY_TMO  = 3;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ISSUE     = 3'd1,
      ST_WAIT_BUSY = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_DONE      = 3'd4
   } arb_state_t;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int unsigned DEF_IDX_W = idx_width(DEF_NREQ);

endpackage

// File: rtl/sdram_ch_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   mask : requests eligible for round-robin
//   last : index granted last; search starts just after it
//   idx  : winning index (valid when any=1)
//   any  : at least one mask bit set
module rr_pick #(
   parameter int unsigned N  = 3,
   parameter int unsigned IW = 2
) (
   input  logic [N-1:0]  mask,
   input  logic [IW-1:0] last,
   output logic [IW-1:0] idx,
   output logic          any
);

   // Scan last+1 .. last+N (wrapping); first hit wins.
   always_comb begin
      int unsigned cand;
      cand = 0;
      idx  = '0;
      any  = 1'b0;
      for (int unsigned off = 1; off <= N; off++) begin
         cand = (32'(last) + off) % N;
         if (!any && mask[IW'(cand)]) begin
            any = 1'b1;
            idx = IW'(cand);
         end
      end
   end

endmodule

// File: rtl/sdram_ch_arbiter.sv
// Shares one SDRAM controller channel between NREQ byte-wide requesters.
// Requester 0 (CPU) has priority, bounded to CPU_BURST consecutive grants
// while others wait; the rest are served round-robin.
//   clk, reset_n          : memory clock, async active-low reset
//   req_valid/we/addr/din : per-requester request (held until req_ready)
//   req_ready             : one-cycle accept pulse (same cycle as strobe)
//   rsp_valid, rsp_data   : one-cycle completion pulse, shared read data
//   mem_rd/wr/addr/din    : strobes and payload to the SDRAM channel
//   mem_dout, mem_busy    : read data and busy from the SDRAM channel
//   err_tmo               : sticky, busy never rose within BUSY_TMO cycles
module sdram_ch_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int unsigned NREQ      = DEF_NREQ,
   parameter int unsigned AW        = 25,
   parameter int unsigned CPU_BURST = DEF_CPU_BURST,
   parameter int unsigned BUSY_TMO  = DEF_BUSY_TMO
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ-1:0]   req_we,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*8-1:0] req_din,
   output logic [NREQ-1:0]   req_ready,
   output logic [NREQ-1:0]   rsp_valid,
   output logic [7:0]        rsp_data,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [AW-1:0]     mem_addr,
   output logic [7:0]        mem_din,
   input  logic [7:0]        mem_dout,
   input  logic              mem_busy,
   output logic              err_tmo
);

   localparam int unsigned IW = idx_width(NREQ);
   localparam int unsigned CW = $clog2(CPU_BURST + 1);
   localparam int unsigned TW = $clog2(BUSY_TMO + 1);

   arb_state_t    state, state_nx;
   logic [IW-1:0] gnt_idx;
   logic [IW-1:0] last_rr;
   logic [CW-1:0] cpu_cnt;
   logic [TW-1:0] tmo_cnt;
   logic          busy_seen;
   logic          is_wr;

   logic [NREQ-1:0] others;
   logic [IW-1:0]   rr_idx;
   logic            rr_any;
   logic            cpu_yield;
   logic            pick_cpu;
   logic [IW-1:0]   win_idx;
   logic            do_grant;
   logic            do_done;
   logic            set_tmo;

   // Round-robin among requesters 1..NREQ-1 only.
   assign others = req_valid & ~NREQ'(1);

   rr_pick #(.N(NREQ), .IW(IW)) u_rr_pick (
      .mask (others),
      .last (last_rr),
      .idx  (rr_idx),
      .any  (rr_any)
   );

   // CPU yields once it has used its burst and someone else is waiting.
   assign cpu_yield = (cpu_cnt == CW'(CPU_BURST)) && rr_any;
   assign pick_cpu  = req_valid[0] && !cpu_yield;
   assign win_idx   = pick_cpu ? '0 : rr_idx;

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nx;
   end

   // Next state and transition events.
   always_comb begin
      state_nx = state;
      do_grant = 1'b0;
      do_done  = 1'b0;
      set_tmo  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (|req_valid) begin
               state_nx = ST_ISSUE;
               do_grant = 1'b1;
            end
         end
         ST_ISSUE: state_nx = ST_WAIT_BUSY;
         ST_WAIT_BUSY: begin
            if (mem_busy || busy_seen) begin
               state_nx = ST_WAIT_DONE;
            end else if (tmo_cnt == TW'(BUSY_TMO - 1)) begin
               state_nx = ST_DONE;
               do_done  = 1'b1;
               set_tmo  = 1'b1;
            end
         end
         ST_WAIT_DONE: begin
            if (!mem_busy) begin
               state_nx = ST_DONE;
               do_done  = 1'b1;
            end
         end
         ST_DONE: state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   // Grant bookkeeping, channel drive and response registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         gnt_idx   <= '0;
         last_rr   <= IW'(NREQ - 1);
         cpu_cnt   <= '0;
         tmo_cnt   <= '0;
         busy_seen <= 1'b0;
         is_wr     <= 1'b0;
         req_ready <= '0;
         rsp_valid <= '0;
         rsp_data  <= '0;
         mem_rd    <= 1'b0;
         mem_wr    <= 1'b0;
         mem_addr  <= '0;
         mem_din   <= '0;
         err_tmo   <= 1'b0;
      end else begin
         req_ready <= '0;
         rsp_valid <= '0;
         mem_rd    <= 1'b0;
         mem_wr    <= 1'b0;

         if (do_grant) begin
            gnt_idx   <= win_idx;
            is_wr     <= req_we[win_idx];
            mem_addr  <= req_addr[win_idx*AW +: AW];
            mem_din   <= req_din[win_idx*8 +: 8];
            mem_rd    <= !req_we[win_idx];
            mem_wr    <= req_we[win_idx];
            req_ready <= NREQ'(1) << win_idx;
            tmo_cnt   <= '0;
            busy_seen <= 1'b0;
            if (pick_cpu) begin
               // Burst only counts while someone else is waiting.
               if (!rr_any)                      cpu_cnt <= '0;
               else if (cpu_cnt != CW'(CPU_BURST)) cpu_cnt <= cpu_cnt + CW'(1);
            end else begin
               cpu_cnt <= '0;
               last_rr <= rr_idx;
            end
         end else if (req_valid == NREQ'(1)) begin
            cpu_cnt <= '0;
         end

         // Busy already high during the strobe cycle counts as the rise.
         if (state == ST_ISSUE) busy_seen <= mem_busy;

         if (state == ST_WAIT_BUSY) tmo_cnt <= tmo_cnt + TW'(1);

         if (do_done) begin
            rsp_valid <= NREQ'(1) << gnt_idx;
            if (!is_wr) rsp_data <= mem_dout;
         end

         if (set_tmo) err_tmo <= 1'b1;
      end
   end

endmodule
